// File: rtl/tag_alloc_ctrl.sv
// Physical-tag allocation sequencer: prefetches free tags into a FIFO and grants them to rename slots.
// Optional stall-cycle statistics port is enabled by defining TAG_ALLOC_STATS_EN.
module tag_alloc_ctrl #(
    parameter int NUM_UOPS    = 3,
    parameter int QDEPTH      = 8,
    parameter int TAG_W       = 6,
    parameter int RECOVER_CYC = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      IN_mispr,
    input  logic [NUM_UOPS*TAG_W-1:0] IN_freeTags,
    input  logic [NUM_UOPS-1:0]       IN_freeTagsValid,
    output logic [NUM_UOPS-1:0]       OUT_freeTake,
    input  logic [NUM_UOPS-1:0]       IN_req,
    output logic [NUM_UOPS-1:0]       OUT_grant,
    output logic [NUM_UOPS*TAG_W-1:0] OUT_tag,
    output logic                      OUT_stall,
    output logic [1:0]                OUT_state,
    output logic [$clog2(QDEPTH):0]   OUT_count
`ifdef TAG_ALLOC_STATS_EN
    ,
    output logic [31:0]               OUT_stallCycles
`endif
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int FC_W  = $clog2(RECOVER_CYC + 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        REFILL = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [FC_W-1:0]    fc_q, fc_d;
    logic [TAG_W-1:0]   fifo_q [QDEPTH];
    logic [TAG_W-1:0]   fifo_d [QDEPTH];

    logic [CNT_W-1:0]   n_req, gcnt, tcnt, space;
    logic [PTR_W-1:0]   idx;
    logic               grant_ok, take_ok;

    always_comb begin
        state_d      = state_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        count_d      = count_q;
        fc_d         = fc_q;
        fifo_d       = fifo_q;
        OUT_grant    = '0;
        OUT_tag      = '0;
        OUT_freeTake = '0;
        OUT_stall    = 1'b1;
        n_req        = '0;
        gcnt         = '0;
        tcnt         = '0;
        idx          = '0;
        space        = CNT_W'(QDEPTH) - count_q;

        for (int i = 0; i < NUM_UOPS; i++)
            n_req = n_req + CNT_W'(IN_req[i]);

        // Atomic group: every requester is served or none is.
        grant_ok = rst && !IN_mispr && (state_q == RUN) && (n_req <= count_q);
        take_ok  = rst && !IN_mispr && ((state_q == RUN) || (state_q == REFILL));

        if (grant_ok) begin
            for (int i = 0; i < NUM_UOPS; i++) begin
                if (IN_req[i]) begin
                    idx                          = rd_q + PTR_W'(gcnt);
                    OUT_grant[i]                 = 1'b1;
                    OUT_tag[i*TAG_W +: TAG_W]    = fifo_q[idx];
                    gcnt                         = gcnt + 1'b1;
                end
            end
        end

        if (rst && (state_q == RUN) && (grant_ok || (n_req == '0)))
            OUT_stall = 1'b0;

        // Space uses the registered count, so same-cycle grants free nothing yet.
        if (take_ok) begin
            for (int i = 0; i < NUM_UOPS; i++) begin
                if (IN_freeTagsValid[i] && (tcnt < space)) begin
                    idx             = wr_q + PTR_W'(tcnt);
                    OUT_freeTake[i] = 1'b1;
                    fifo_d[idx]     = IN_freeTags[i*TAG_W +: TAG_W];
                    tcnt            = tcnt + 1'b1;
                end
            end
        end

        count_d = count_q - gcnt + tcnt;
        rd_d    = rd_q + PTR_W'(gcnt);
        wr_d    = wr_q + PTR_W'(tcnt);

        if (IN_mispr) begin
            state_d = FLUSH;
            count_d = '0;
            rd_d    = wr_q;
            fc_d    = FC_W'(RECOVER_CYC);
        end else begin
            case (state_q)
                FLUSH: begin
                    if (fc_q <= FC_W'(1)) begin
                        state_d = REFILL;
                        fc_d    = '0;
                    end else begin
                        fc_d = fc_q - 1'b1;
                    end
                end
                REFILL: if (count_d >= CNT_W'(NUM_UOPS)) state_d = RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= REFILL;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            fc_q    <= fc_d;
        end
    end

    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign OUT_state = state_q;
    assign OUT_count = count_q;

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst) count_q >= gcnt);

`ifdef TAG_ALLOC_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (rst && (state_q == RUN) && (|IN_req) && OUT_stall && (stall_cycles_q != 32'hFFFF_FFFF))
            stall_cycles_d = stall_cycles_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) stall_cycles_q <= '0;
        else      stall_cycles_q <= stall_cycles_d;
    end

    assign OUT_stallCycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_tag_alloc_ctrl.sv
// Bench for tag_alloc_ctrl: directed vector table, then random traffic against a queue-based model.
module tb_tag_alloc_ctrl;

    localparam int NU = 3;
    localparam int TW = 6;
    localparam int QD = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             IN_mispr;
    logic [NU*TW-1:0] IN_freeTags;
    logic [NU-1:0]    IN_freeTagsValid;
    logic [NU-1:0]    OUT_freeTake;
    logic [NU-1:0]    IN_req;
    logic [NU-1:0]    OUT_grant;
    logic [NU*TW-1:0] OUT_tag;
    logic             OUT_stall;
    logic [1:0]       OUT_state;
    logic [3:0]       OUT_count;
`ifdef TAG_ALLOC_STATS_EN
    logic [31:0]      OUT_stallCycles;
`endif

    tag_alloc_ctrl dut (
        .clk(clk), .rst(rst), .IN_mispr(IN_mispr),
        .IN_freeTags(IN_freeTags), .IN_freeTagsValid(IN_freeTagsValid),
        .OUT_freeTake(OUT_freeTake), .IN_req(IN_req), .OUT_grant(OUT_grant),
        .OUT_tag(OUT_tag), .OUT_stall(OUT_stall), .OUT_state(OUT_state),
        .OUT_count(OUT_count)
`ifdef TAG_ALLOC_STATS_EN
        , .OUT_stallCycles(OUT_stallCycles)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit       r;
        bit       m;
        bit [2:0] v;
        int       base;
        bit [2:0] rq;
        bit [2:0] etake;
        bit [2:0] egr;
        int       t0, t1, t2;
        bit       est;
        int       estate;
        int       ecount;
    } vec_t;

    vec_t vecs[26];

    task automatic set_tags(input int base);
        for (int i = 0; i < NU; i++) IN_freeTags[i*TW +: TW] = TW'((base + i) % 64);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a queue of tags plus the FSM as plain integers.
    int mq[$];
    int mstate;
    int mfc;

    task automatic model_step();
        logic [NU-1:0]    e_take, e_grant;
        logic [NU*TW-1:0] e_tag;
        logic             e_stall;
        int n, k, space, t;
        e_take = '0; e_grant = '0; e_tag = '0; e_stall = 1'b1;
        n = $countones(IN_req);
        if (rst) begin
            if (mstate == 0 && !IN_mispr && n <= mq.size()) begin
                e_grant = IN_req;
                k = 0;
                for (int i = 0; i < NU; i++)
                    if (IN_req[i]) begin e_tag[i*TW +: TW] = TW'(mq[k]); k++; end
            end
            e_stall = (mstate != 0) || (n != 0 && e_grant == '0);
            if (!IN_mispr && mstate != 1) begin
                space = QD - mq.size();
                t = 0;
                for (int i = 0; i < NU; i++)
                    if (IN_freeTagsValid[i] && t < space) begin e_take[i] = 1'b1; t++; end
            end
        end
        chk("rnd_state", 32'(OUT_state), 32'(mstate));
        chk("rnd_count", 32'(OUT_count), 32'(mq.size()));
        chk("rnd_grant", 32'(OUT_grant), 32'(e_grant));
        chk("rnd_tag",   32'(OUT_tag),   32'(e_tag));
        chk("rnd_take",  32'(OUT_freeTake), 32'(e_take));
        chk("rnd_stall", 32'(OUT_stall), 32'(e_stall));
        if (!rst) begin
            mq.delete(); mstate = 2; mfc = 0;
        end else if (IN_mispr) begin
            mq.delete(); mstate = 1; mfc = 2;
        end else begin
            if (e_grant != '0) for (int i = 0; i < n; i++) void'(mq.pop_front());
            for (int i = 0; i < NU; i++)
                if (e_take[i]) mq.push_back(int'(IN_freeTags[i*TW +: TW]));
            if (mstate == 1) begin
                if (mfc <= 1) mstate = 2; else mfc--;
            end else if (mstate == 2 && mq.size() >= 3) begin
                mstate = 0;
            end
        end
    endtask

    initial begin
        logic [NU*TW-1:0] etag;
        int next_tag;
        int hi;

        //        r  m  v      base rq     take   grant  t0 t1 t2 stall st cnt
        vecs[0]  = '{0, 0, 3'b111, 32, 3'b111, 3'b000, 3'b000, 0, 0, 0, 1, 2, 0};
        vecs[1]  = '{1, 0, 3'b111, 32, 3'b000, 3'b111, 3'b000, 0, 0, 0, 1, 2, 0};
        vecs[2]  = '{1, 0, 3'b000, 32, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0, 0, 3};
        vecs[3]  = '{1, 0, 3'b000, 32, 3'b001, 3'b000, 3'b001, 32, 0, 0, 0, 0, 3};
        vecs[4]  = '{1, 0, 3'b000, 32, 3'b111, 3'b000, 3'b000, 0, 0, 0, 1, 0, 2};
        vecs[5]  = '{1, 0, 3'b000, 32, 3'b101, 3'b000, 3'b101, 33, 0, 34, 0, 0, 2};
        vecs[6]  = '{1, 0, 3'b111, 40, 3'b000, 3'b111, 3'b000, 0, 0, 0, 0, 0, 0};
        vecs[7]  = '{1, 0, 3'b111, 43, 3'b000, 3'b111, 3'b000, 0, 0, 0, 0, 0, 3};
        vecs[8]  = '{1, 0, 3'b111, 46, 3'b000, 3'b011, 3'b000, 0, 0, 0, 0, 0, 6};
        vecs[9]  = '{1, 0, 3'b111, 50, 3'b111, 3'b000, 3'b111, 40, 41, 42, 0, 0, 8};
        vecs[10] = '{1, 0, 3'b111, 50, 3'b000, 3'b111, 3'b000, 0, 0, 0, 0, 0, 5};
        vecs[11] = '{1, 0, 3'b000, 50, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0, 0, 8};
        vecs[12] = '{1, 1, 3'b111, 60, 3'b111, 3'b000, 3'b000, 0, 0, 0, 1, 0, 8};
        vecs[13] = '{1, 0, 3'b111, 60, 3'b111, 3'b000, 3'b000, 0, 0, 0, 1, 1, 0};
        vecs[14] = '{1, 0, 3'b111, 60, 3'b111, 3'b000, 3'b000, 0, 0, 0, 1, 1, 0};
        vecs[15] = '{1, 0, 3'b011, 60, 3'b000, 3'b011, 3'b000, 0, 0, 0, 1, 2, 0};
        vecs[16] = '{1, 0, 3'b111, 62, 3'b111, 3'b111, 3'b000, 0, 0, 0, 1, 2, 2};
        vecs[17] = '{1, 0, 3'b000, 62, 3'b111, 3'b000, 3'b111, 60, 61, 62, 0, 0, 5};
        vecs[18] = '{1, 0, 3'b000, 62, 3'b010, 3'b000, 3'b010, 0, 63, 0, 0, 0, 2};
        vecs[19] = '{1, 1, 3'b000, 62, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0, 0, 1};
        vecs[20] = '{1, 0, 3'b000, 62, 3'b000, 3'b000, 3'b000, 0, 0, 0, 1, 1, 0};
        vecs[21] = '{1, 0, 3'b000, 62, 3'b000, 3'b000, 3'b000, 0, 0, 0, 1, 1, 0};
        vecs[22] = '{1, 0, 3'b001, 10, 3'b000, 3'b001, 3'b000, 0, 0, 0, 1, 2, 0};
        vecs[23] = '{0, 1, 3'b111, 10, 3'b111, 3'b000, 3'b000, 0, 0, 0, 1, 2, 1};
        vecs[24] = '{0, 1, 3'b111, 10, 3'b111, 3'b000, 3'b000, 0, 0, 0, 1, 2, 0};
        vecs[25] = '{1, 0, 3'b000, 10, 3'b000, 3'b000, 3'b000, 0, 0, 0, 1, 2, 0};

        rst = 1'b0; IN_mispr = 1'b0; IN_req = '0; IN_freeTagsValid = '0; IN_freeTags = '0;
        next_cycle();
        next_cycle();

        for (int v = 0; v < 26; v++) begin
            rst = vecs[v].r; IN_mispr = vecs[v].m;
            IN_freeTagsValid = vecs[v].v; IN_req = vecs[v].rq;
            set_tags(vecs[v].base);
            etag = '0;
            if (vecs[v].egr[0]) etag[0*TW +: TW] = TW'(vecs[v].t0);
            if (vecs[v].egr[1]) etag[1*TW +: TW] = TW'(vecs[v].t1);
            if (vecs[v].egr[2]) etag[2*TW +: TW] = TW'(vecs[v].t2);
            #2;
            chk($sformatf("v%0d_state", v), 32'(OUT_state), 32'(vecs[v].estate));
            chk($sformatf("v%0d_count", v), 32'(OUT_count), 32'(vecs[v].ecount));
            chk($sformatf("v%0d_take", v),  32'(OUT_freeTake), 32'(vecs[v].etake));
            chk($sformatf("v%0d_grant", v), 32'(OUT_grant), 32'(vecs[v].egr));
            chk($sformatf("v%0d_tag", v),   32'(OUT_tag), 32'(etag));
            chk($sformatf("v%0d_stall", v), 32'(OUT_stall), 32'(vecs[v].est));
            next_cycle();
        end

        rst = 1'b0; IN_mispr = 1'b0; IN_req = '0; IN_freeTagsValid = '0;
        next_cycle();
        mq.delete(); mstate = 2; mfc = 0;
        next_tag = 0;
        for (int c = 0; c < 400; c++) begin
            rst              = ($urandom_range(0, 59) != 0);
            IN_mispr         = ($urandom_range(0, 19) == 0);
            IN_freeTagsValid = NU'($urandom_range(0, 7));
            IN_req           = ($urandom_range(0, 2) == 0) ? 3'b000 : NU'($urandom_range(0, 7));
            set_tags(next_tag);
            #2;
            hi = 0;
            for (int i = 0; i < NU; i++) if (OUT_freeTake[i]) hi = i + 1;
            model_step();
            next_tag = (next_tag + hi) % 64;
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
